md5_match_capture: RTL

- Sits directly downstream of the 64-stage MD5 core and consumes its digest words, message block and valid flag every enabled cycle.
- Compares each 128-bit digest against a host-loaded target hash and counts the hashes processed.
- On a match, captures the fixed-length candidate string and holds it for the host/UART readback logic until that logic acknowledges it.

---
 rtl/md5_match_capture.sv | 114 +++++++++++
 1 files changed

// File: rtl/md5_match_capture.sv
// Two-stage digest comparator behind the MD5 core: counts valid digests and
// holds the first matching candidate string until the host acknowledges it.
module md5_match_capture #(
  parameter int STR_LEN = 19,
  parameter int CNT_W   = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   en,
  input  logic                   target_load,
  input  logic [127:0]           target_hash,
  input  logic [31:0]            a_in,
  input  logic [31:0]            b_in,
  input  logic [31:0]            c_in,
  input  logic [31:0]            d_in,
  input  logic [511:0]           m_in,
  input  logic                   valid_in,
  input  logic                   match_ack,
  output logic                   match_valid,
  output logic [STR_LEN*8-1:0]   match_str,
  output logic [CNT_W-1:0]       hash_count,
  output logic                   missed_match
);

  localparam int SW = STR_LEN * 8;

  typedef enum logic {ARMED, HOLD} state_e;

  logic [127:0]   target_q;
  logic           eqS1_q;
  logic [SW-1:0]  strS1_q;
  logic           validS1_q;
  logic [CNT_W-1:0] hashCount_q, hashCount_d;
  state_e         state_q;
  logic           matchValid_q;
  logic [SW-1:0]  matchStr_q;
  logic           missed_q;
  logic           hit;

  // Stage 1; a target load flushes the compare made against the old target
  always_ff @(posedge clk) begin
    if (reset) begin
      target_q  <= '0;
      eqS1_q    <= 1'b0;
      strS1_q   <= '0;
      validS1_q <= 1'b0;
    end else if (target_load) begin
      target_q  <= target_hash;
      validS1_q <= 1'b0;
    end else if (en) begin
      eqS1_q    <= ({a_in, b_in, c_in, d_in} == target_q);
      strS1_q   <= m_in[511 -: SW];
      validS1_q <= valid_in;
    end
  end

  assign hit = en & validS1_q & eqS1_q;

  always_comb begin
    hashCount_d = hashCount_q;
    if (target_load)
      hashCount_d = '0;
    else if (en && validS1_q && (hashCount_q != {CNT_W{1'b1}}))
      hashCount_d = hashCount_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) hashCount_q <= '0;
    else       hashCount_q <= hashCount_d;
  end

  // Capture FSM; an ack coinciding with a hit hands the slot straight to the new string
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ARMED;
      matchValid_q <= 1'b0;
      matchStr_q   <= '0;
      missed_q     <= 1'b0;
    end else if (target_load) begin
      state_q      <= ARMED;
      matchValid_q <= 1'b0;
      missed_q     <= 1'b0;
    end else begin
      case (state_q)
        ARMED: begin
          if (hit) begin
            matchStr_q   <= strS1_q;
            matchValid_q <= 1'b1;
            state_q      <= HOLD;
          end
        end
        HOLD: begin
          if (match_ack) begin
            if (hit) begin
              matchStr_q <= strS1_q;
            end else begin
              matchValid_q <= 1'b0;
              state_q      <= ARMED;
            end
          end else if (hit) begin
            missed_q <= 1'b1;
          end
        end
        default: state_q <= ARMED;
      endcase
    end
  end

  assign match_valid  = matchValid_q;
  assign match_str    = matchStr_q;
  assign hash_count   = hashCount_q;
  assign missed_match = missed_q;

endmodule
